uart_frame_sequencer: RTL and testbench

UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

---
 rtl/uart_frame_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer.sv
// rtl/uart_frame_sequencer.sv - UART frame sequencer: RX words to data RAM, compute handshake, result RAM out to UART TX
module uart_frame_sequencer #(
    parameter int WORD_WIDTH      = 16,
    parameter int N_IN            = 512,
    parameter int IN_ADDR_BITS    = 9,
    parameter int ROW_LEN         = 512,
    parameter int ROW_BITS        = 9,
    parameter int N_ROWS          = 8,
    parameter int ROW_SEL_BITS    = 3,
    parameter int RX_TIMEOUT      = 12500,
    parameter int COMPUTE_TIMEOUT = 1048575
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Rx_valid,
    input  logic [WORD_WIDTH-1:0]   Rx_data,
    output logic                    Data_wr_en,
    output logic [IN_ADDR_BITS-1:0] Data_wr_addr,
    output logic [WORD_WIDTH-1:0]   Data_wr_data,
    output logic                    Compute_enable,
    input  logic                    Compute_done,
    output logic                    Res_rd_en,
    output logic [ROW_SEL_BITS-1:0] Res_rd_depth,
    output logic [ROW_BITS-1:0]     Res_rd_width,
    input  logic [WORD_WIDTH-1:0]   Res_rd_data,
    output logic                    Tx_start,
    output logic [WORD_WIDTH-1:0]   Tx_data,
    input  logic                    Tx_idle,
    input  logic                    Clear_err,
    output logic                    Err_rx_timeout,
    output logic                    Err_compute_timeout,
    output logic [15:0]             Frame_count,
    output logic [2:0]              State
);

    localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

    localparam logic [IN_ADDR_BITS-1:0] LAST_IN   = IN_ADDR_BITS'(N_IN - 1);
    localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);
    localparam logic [23:0]             WD_LAST   = 24'(COMPUTE_TIMEOUT - 1);
    localparam logic [ROW_BITS-1:0]     COL_LAST  = ROW_BITS'(ROW_LEN - 1);
    localparam logic [ROW_SEL_BITS-1:0] ROW_LAST  = ROW_SEL_BITS'(N_ROWS - 1);

    typedef enum logic [2:0] {
        S_RX      = 3'd0,
        S_COMPUTE = 3'd1,
        S_TX_ADDR = 3'd2,
        S_TX_LOAD = 3'd3,
        S_TX_SEND = 3'd4,
        S_TX_WAIT = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IN_ADDR_BITS-1:0] word_cnt;
    logic [IDLE_W-1:0]       idle_cnt;
    logic [23:0]             wd_cnt;
    logic [ROW_SEL_BITS-1:0] row;
    logic [ROW_BITS-1:0]     col;

    logic rx_write;
    logic rx_last;
    logic rx_idle_tick;
    logic rx_timeout;
    logic cmp_timeout;
    logic word_done;
    logic frame_done;

    assign rx_write     = (state == S_RX) && Rx_valid;
    assign rx_last      = rx_write && (word_cnt == LAST_IN);
    assign rx_idle_tick = (state == S_RX) && !Rx_valid && (word_cnt != '0);
    assign rx_timeout   = rx_idle_tick && (idle_cnt == IDLE_LAST);
    assign cmp_timeout  = (state == S_COMPUTE) && !Compute_done && (wd_cnt == WD_LAST);
    // Tx_start is high only in the first TX_WAIT cycle, which doubles as the "ignore Tx_idle" marker
    assign word_done    = (state == S_TX_WAIT) && !Tx_start && Tx_idle;
    assign frame_done   = word_done && (col == COL_LAST) && (row == ROW_LAST);

    assign Compute_enable = (state == S_COMPUTE);
    assign Res_rd_en      = (state == S_TX_ADDR);
    assign Res_rd_depth   = row;
    assign Res_rd_width   = col;
    assign State          = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_RX;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RX:      if (rx_last) state_nxt = S_COMPUTE;
            S_COMPUTE: begin
                if (Compute_done) begin
                    state_nxt = S_TX_ADDR;
                end else if (cmp_timeout) begin
                    state_nxt = S_RX;
                end
            end
            S_TX_ADDR: state_nxt = S_TX_LOAD;
            S_TX_LOAD: state_nxt = S_TX_SEND;
            S_TX_SEND: if (Tx_idle) state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (frame_done) begin
                    state_nxt = S_RX;
                end else if (word_done) begin
                    state_nxt = S_TX_ADDR;
                end
            end
            default:   state_nxt = S_RX;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Data_wr_en          <= 1'b0;
            Data_wr_addr        <= '0;
            Data_wr_data        <= '0;
            word_cnt            <= '0;
            idle_cnt            <= '0;
            wd_cnt              <= '0;
            row                 <= '0;
            col                 <= '0;
            Tx_start            <= 1'b0;
            Tx_data             <= '0;
            Err_rx_timeout      <= 1'b0;
            Err_compute_timeout <= 1'b0;
            Frame_count         <= '0;
        end else begin
            Data_wr_en <= rx_write;
            if (rx_write) begin
                Data_wr_addr <= word_cnt;
                Data_wr_data <= Rx_data;
            end

            if (rx_last || rx_timeout) begin
                word_cnt <= '0;
            end else if (rx_write) begin
                word_cnt <= word_cnt + 1'b1;
            end

            if (rx_write || rx_timeout || (state != S_RX)) begin
                idle_cnt <= '0;
            end else if (rx_idle_tick) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if ((state != S_COMPUTE) || Compute_done || cmp_timeout) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            Tx_start <= (state == S_TX_SEND) && Tx_idle;
            if (state == S_TX_LOAD) begin
                Tx_data <= Res_rd_data;
            end

            if (word_done) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (frame_done) begin
                Frame_count <= Frame_count + 16'd1;
            end

            // A new error event in the same cycle as Clear_err keeps the flag set
            if (rx_timeout) begin
                Err_rx_timeout <= 1'b1;
            end else if (Clear_err) begin
                Err_rx_timeout <= 1'b0;
            end
            if (cmp_timeout) begin
                Err_compute_timeout <= 1'b1;
            end else if (Clear_err) begin
                Err_compute_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb/tb_uart_frame_sequencer.sv - directed-vector bench for uart_frame_sequencer
module tb_uart_frame_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Rx_valid = 1'b0;
    logic [15:0] Rx_data = '0;
    logic        Data_wr_en;
    logic [1:0]  Data_wr_addr;
    logic [15:0] Data_wr_data;
    logic        Compute_enable;
    logic        Compute_done = 1'b0;
    logic        Res_rd_en;
    logic        Res_rd_depth;
    logic        Res_rd_width;
    logic [15:0] Res_rd_data = '0;
    logic        Tx_start;
    logic [15:0] Tx_data;
    logic        Tx_idle;
    logic        Clear_err = 1'b0;
    logic        Err_rx_timeout;
    logic        Err_compute_timeout;
    logic [15:0] Frame_count;
    logic [2:0]  State;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] res_mem [4];
    logic [15:0] exp_tx [4];
    logic [15:0] tx_log [$];
    int          tx_busy = 0;

    uart_frame_sequencer #(
        .WORD_WIDTH(16), .N_IN(4), .IN_ADDR_BITS(2), .ROW_LEN(2), .ROW_BITS(1),
        .N_ROWS(2), .ROW_SEL_BITS(1), .RX_TIMEOUT(10), .COMPUTE_TIMEOUT(50)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx_valid(Rx_valid), .Rx_data(Rx_data),
        .Data_wr_en(Data_wr_en), .Data_wr_addr(Data_wr_addr), .Data_wr_data(Data_wr_data),
        .Compute_enable(Compute_enable), .Compute_done(Compute_done),
        .Res_rd_en(Res_rd_en), .Res_rd_depth(Res_rd_depth), .Res_rd_width(Res_rd_width),
        .Res_rd_data(Res_rd_data), .Tx_start(Tx_start), .Tx_data(Tx_data), .Tx_idle(Tx_idle),
        .Clear_err(Clear_err), .Err_rx_timeout(Err_rx_timeout),
        .Err_compute_timeout(Err_compute_timeout), .Frame_count(Frame_count), .State(State)
    );

    always #5 Clk = ~Clk;

    // Result RAM with one-cycle read latency, rows {A,B},{C,D}
    always @(posedge Clk) begin
        if (Res_rd_en) Res_rd_data <= res_mem[{Res_rd_depth, Res_rd_width}];
    end

    // UART TX: idle drops the cycle after a start is seen and stays low for 20 cycles
    assign Tx_idle = (tx_busy == 0);
    always @(posedge Clk) begin
        if (tx_busy > 0) begin
            tx_busy <= tx_busy - 1;
        end else if (Tx_start) begin
            tx_busy <= 20;
        end
        if (Tx_start) tx_log.push_back(Tx_data);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        Rx_valid = 1'b1;
        Rx_data  = d;
        tick();
        Rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (State !== 3'd0 || Data_wr_en !== 1'b0 || Compute_enable !== 1'b0 || Res_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: State=%0d wr=%b ce=%b rd=%b, required 0 0 0 0", State, Data_wr_en, Compute_enable, Res_rd_en);
        end
        vectors++;
        if (Tx_start !== 1'b0 || Tx_data !== 16'h0 || Frame_count !== 16'd0 || Err_rx_timeout !== 1'b0 || Err_compute_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx: start=%b data=%h fc=%0d erx=%b ecmp=%b, required 0 0000 0 0 0", Tx_start, Tx_data, Frame_count, Err_rx_timeout, Err_compute_timeout);
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic rx_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3, input string tag);
        logic [15:0] words [4];
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        for (int i = 0; i < 4; i++) begin
            send_word(words[i]);
            vectors++;
            if (Data_wr_en !== 1'b1 || Data_wr_addr !== 2'(i) || Data_wr_data !== words[i]) begin
                miscompares++;
                $display("FAIL %s_write%0d: en=%b addr=%0d data=%h, required 1 %0d %h", tag, i, Data_wr_en, Data_wr_addr, Data_wr_data, i, words[i]);
            end
        end
        vectors++;
        if (State !== 3'd1 || Compute_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_enter_compute: State=%0d ce=%b, required 1 1", tag, State, Compute_enable);
        end
    endtask

    task automatic finish_compute(input string tag);
        for (int i = 0; i < 4; i++) tick();
        Compute_done = 1'b1;
        tick();
        Compute_done = 1'b0;
        vectors++;
        if (Compute_enable !== 1'b0 || State !== 3'd2) begin
            miscompares++;
            $display("FAIL %s_done: ce=%b State=%0d, required 0 2", tag, Compute_enable, State);
        end
    endtask

    task automatic check_tx_frame(input int base, input string tag);
        int n;
        n = 0;
        while (State !== 3'd0 && n < 600) begin
            tick();
            n++;
        end
        vectors++;
        if (State !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_tx_bound: State=%0d after %0d cycles, required 0", tag, State, n);
        end
        vectors++;
        if (tx_log.size() - base !== 4) begin
            miscompares++;
            $display("FAIL %s_start_count: got %0d, required 4", tag, tx_log.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (base + i >= tx_log.size() || tx_log[base + i] !== exp_tx[i]) begin
                miscompares++;
                $display("FAIL %s_tx_word%0d: got %h, required %h", tag, i, (base + i < tx_log.size()) ? tx_log[base + i] : 16'hxxxx, exp_tx[i]);
            end
        end
        vectors++;
        if (Frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL %s_frame_count: got %0d, required 1", tag, Frame_count);
        end
    endtask

    task automatic test_frame();
        int base;
        base = tx_log.size();
        rx_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, "frame");
        Rx_valid = 1'b1;
        Rx_data  = 16'h00EE;
        tick();
        Rx_valid = 1'b0;
        vectors++;
        if (Data_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_in_compute: wr_en=%b, required 0", Data_wr_en);
        end
        finish_compute("frame");
        check_tx_frame(base, "frame");
    endtask

    task automatic test_rx_timeout();
        send_word(16'h0055);
        send_word(16'h0066);
        for (int i = 0; i < 9; i++) tick();
        vectors++;
        if (Err_rx_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_timeout_early: got %b after 9 idle cycles, required 0", Err_rx_timeout);
        end
        Clear_err = 1'b1;
        tick();
        vectors++;
        if (Err_rx_timeout !== 1'b1 || State !== 3'd0) begin
            miscompares++;
            $display("FAIL rx_timeout_set_wins: err=%b State=%0d, required 1 0", Err_rx_timeout, State);
        end
        tick();
        Clear_err = 1'b0;
        vectors++;
        if (Err_rx_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_timeout_clear: got %b, required 0", Err_rx_timeout);
        end
        rx_frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, "after_timeout");
    endtask

    task automatic test_compute_timeout();
        int base;
        base = tx_log.size();
        for (int i = 0; i < 49; i++) tick();
        vectors++;
        if (State !== 3'd1 || Err_compute_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_timeout_early: State=%0d err=%b, required 1 0", State, Err_compute_timeout);
        end
        tick();
        vectors++;
        if (State !== 3'd0 || Err_compute_timeout !== 1'b1 || Compute_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_timeout_fire: State=%0d err=%b ce=%b, required 0 1 0", State, Err_compute_timeout, Compute_enable);
        end
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (tx_log.size() !== base) begin
            miscompares++;
            $display("FAIL cmp_timeout_no_tx: %0d starts, required 0", tx_log.size() - base);
        end
        Clear_err = 1'b1;
        tick();
        Clear_err = 1'b0;
        vectors++;
        if (Err_compute_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_timeout_clear: got %b, required 0", Err_compute_timeout);
        end
    endtask

    task automatic test_reset_mid_tx();
        int base;
        int seen;
        int n;
        base = tx_log.size();
        rx_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, "pre_rst");
        finish_compute("pre_rst");
        seen = 0;
        n = 0;
        while (seen < 2 && n < 300) begin
            tick();
            n++;
            if (Tx_start === 1'b1) seen++;
        end
        vectors++;
        if (seen != 2 || State !== 3'd5) begin
            miscompares++;
            $display("FAIL mid_tx_reach: starts=%0d State=%0d, required 2 5", seen, State);
        end
        Rst = 1'b1;
        #1;
        vectors++;
        if (State !== 3'd0 || Tx_start !== 1'b0 || Tx_data !== 16'h0 || Frame_count !== 16'd0 || Res_rd_en !== 1'b0 || Data_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_tx_reset: State=%0d start=%b data=%h fc=%0d rd=%b wr=%b, required 0 0 0000 0 0 0", State, Tx_start, Tx_data, Frame_count, Res_rd_en, Data_wr_en);
        end
        tick();
        Rst = 1'b0;
        n = 0;
        while (tx_busy != 0 && n < 50) begin
            tick();
            n++;
        end
        base = tx_log.size();
        rx_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, "post_rst");
        finish_compute("post_rst");
        check_tx_frame(base, "post_rst");
    endtask

    initial begin
        res_mem[0] = 16'hA0A0; res_mem[1] = 16'hB1B1; res_mem[2] = 16'hC2C2; res_mem[3] = 16'hD3D3;
        exp_tx[0]  = 16'hA0A0; exp_tx[1]  = 16'hB1B1; exp_tx[2]  = 16'hC2C2; exp_tx[3]  = 16'hD3D3;
        test_reset();
        test_frame();
        test_rx_timeout();
        test_compute_timeout();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
